load_value_predictor: RTL and testbench

Speculative load-value predictor with architectural register snapshot, placed beside the hazard controller in the MIPS core. On each accepted load it checkpoints the register file, issues a predicted load value from a last-value table, and then compares the prediction against the real D-cache data. On a mismatch it requests pipeline recovery from the snapshot; on a match it signals completion.

---
 rtl/load_value_predictor.sv | 139 +++++++++++++
 tb/tb_load_value_predictor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/load_value_predictor.sv
// Speculative load-value predictor: last-value table with 2-bit confidence plus a register snapshot.
// Optional VP_CONFIDENCE_EN: predictions are only marked usable on a tag hit with confidence >= 2.
module load_value_predictor #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int VPT_ENTRIES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vp_en,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic                           d_cache_valid,
    input  logic [DATA_WIDTH-1:0]          d_cache_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_snapshot,
    output logic                           snapshot_done,
    output logic [DATA_WIDTH-1:0]          out,
    output logic                           out_valid,
    output logic                           vp_lock_out,
    output logic                           done,
    output logic                           en_recover
);

    localparam int IDX_W = $clog2(VPT_ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                          state_q;
    logic [NUM_REGS*DATA_WIDTH-1:0]  snap_q;
    logic [DATA_WIDTH-1:0]           out_q;
    logic                            out_valid_q;
    logic                            lock_q;
    logic                            snapshot_done_q;
    logic                            done_q;
    logic                            en_recover_q;
    logic [IDX_W-1:0]                idx_q;
    logic [TAG_W-1:0]                tag_q;
    logic                            hit_q;

    logic                            vpt_valid_q [VPT_ENTRIES];
    logic [TAG_W-1:0]                vpt_tag_q   [VPT_ENTRIES];
    logic [DATA_WIDTH-1:0]           vpt_value_q [VPT_ENTRIES];
    logic [1:0]                      vpt_conf_q  [VPT_ENTRIES];

    logic [IDX_W-1:0]                idx_d;
    logic [TAG_W-1:0]                tag_d;
    logic                            hit_d;
    logic [DATA_WIDTH-1:0]           pred_d;
    logic                            pred_ok_d;
    logic                            match_d;
    logic [1:0]                      conf_d;
    logic                            unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        idx_d     = addr[IDX_W+1:2];
        tag_d     = addr[ADDR_WIDTH-1:IDX_W+2];
        hit_d     = vpt_valid_q[idx_d] && (vpt_tag_q[idx_d] == tag_d);
        pred_d    = hit_d ? vpt_value_q[idx_d] : '0;
`ifdef VP_CONFIDENCE_EN
        pred_ok_d = hit_d && (vpt_conf_q[idx_d] >= 2'd2);
`else
        pred_ok_d = 1'b1;
`endif
        // out_q keeps the table value even when not marked usable, so training still compares against it
        match_d   = (d_cache_data == out_q);
        conf_d    = '0;
        if (hit_q && match_d) begin
            conf_d = (vpt_conf_q[idx_q] == 2'd3) ? 2'd3 : vpt_conf_q[idx_q] + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            snap_q          <= '0;
            out_q           <= '0;
            out_valid_q     <= 1'b0;
            lock_q          <= 1'b0;
            snapshot_done_q <= 1'b0;
            done_q          <= 1'b0;
            en_recover_q    <= 1'b0;
            idx_q           <= '0;
            tag_q           <= '0;
            hit_q           <= 1'b0;
            for (int unsigned i = 0; i < VPT_ENTRIES; i++) begin
                vpt_valid_q[i] <= 1'b0;
                vpt_tag_q[i]   <= '0;
                vpt_value_q[i] <= '0;
                vpt_conf_q[i]  <= '0;
            end
        end else begin
            snapshot_done_q <= 1'b0;
            done_q          <= 1'b0;
            en_recover_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vp_en) begin
                        snap_q          <= regs_in;
                        idx_q           <= idx_d;
                        tag_q           <= tag_d;
                        hit_q           <= hit_d;
                        out_q           <= pred_d;
                        out_valid_q     <= pred_ok_d;
                        lock_q          <= 1'b1;
                        snapshot_done_q <= 1'b1;
                        state_q         <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (d_cache_valid) begin
                        done_q             <= out_valid_q && match_d;
                        en_recover_q       <= out_valid_q && !match_d;
                        vpt_valid_q[idx_q] <= 1'b1;
                        vpt_tag_q[idx_q]   <= tag_q;
                        vpt_value_q[idx_q] <= d_cache_data;
                        vpt_conf_q[idx_q]  <= conf_d;
                        out_valid_q        <= 1'b0;
                        lock_q             <= 1'b0;
                        state_q            <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign regs_snapshot = snap_q;
    assign snapshot_done = snapshot_done_q;
    assign out           = out_q;
    assign out_valid     = out_valid_q;
    assign vp_lock_out   = lock_q;
    assign done          = done_q;
    assign en_recover    = en_recover_q;

endmodule

// File: tb/tb_load_value_predictor.sv
// Randomized and directed bench for load_value_predictor against a transaction-level table model.
module tb_load_value_predictor;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 32;
    localparam int NE = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vp_en = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic              d_cache_valid = 1'b0;
    logic [DW-1:0]     d_cache_data = '0;
    logic [NR*DW-1:0]  regs_in = '0;
    logic [NR*DW-1:0]  regs_snapshot;
    logic              snapshot_done;
    logic [DW-1:0]     out;
    logic              out_valid;
    logic              vp_lock_out;
    logic              done;
    logic              en_recover;

    int n_checks = 0;
    int n_pass   = 0;

    load_value_predictor #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .VPT_ENTRIES(NE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vp_en        (vp_en),
        .addr         (addr),
        .d_cache_valid(d_cache_valid),
        .d_cache_data (d_cache_data),
        .regs_in      (regs_in),
        .regs_snapshot(regs_snapshot),
        .snapshot_done(snapshot_done),
        .out          (out),
        .out_valid    (out_valid),
        .vp_lock_out  (vp_lock_out),
        .done         (done),
        .en_recover   (en_recover)
    );

    always #5 clk = ~clk;

    // Reference model: the table as plain arrays, one in-flight request
    bit               m_valid [NE];
    int unsigned      m_tag   [NE];
    logic [DW-1:0]    m_val   [NE];
    int               m_conf  [NE];
    bit               m_locked, m_hit, m_pv;
    int unsigned      m_i, m_t;
    logic [DW-1:0]    m_pred;
    logic [NR*DW-1:0] m_snap;
    bit               e_sd, e_done, e_rec;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_val[i] = '0; m_conf[i] = 0;
        end
        m_locked = 0; m_hit = 0; m_pv = 0; m_i = 0; m_t = 0; m_pred = '0; m_snap = '0;
        e_sd = 0; e_done = 0; e_rec = 0;
    endtask

    task automatic model_step();
        bit match;
        e_sd = 0; e_done = 0; e_rec = 0;
        if (!m_locked) begin
            if (vp_en) begin
                m_i    = (addr / 4) % NE;
                m_t    = addr / (4 * NE);
                m_hit  = m_valid[m_i] && (m_tag[m_i] == m_t);
                m_pred = m_hit ? m_val[m_i] : '0;
`ifdef VP_CONFIDENCE_EN
                m_pv   = m_hit && (m_conf[m_i] >= 2);
`else
                m_pv   = 1;
`endif
                m_snap   = regs_in;
                e_sd     = 1;
                m_locked = 1;
            end
        end else if (d_cache_valid) begin
            match  = (d_cache_data == m_pred);
            e_done = m_pv && match;
            e_rec  = m_pv && !match;
            if (m_hit && match) m_conf[m_i] = (m_conf[m_i] + 1 > 3) ? 3 : m_conf[m_i] + 1;
            else m_conf[m_i] = 0;
            m_valid[m_i] = 1; m_tag[m_i] = m_t; m_val[m_i] = d_cache_data;
            m_pv = 0; m_locked = 0;
        end
    endtask

    task automatic compare();
        check("lock", vp_lock_out, m_locked);
        check("out_valid", out_valid, m_pv);
        check("snapshot_done", snapshot_done, e_sd);
        check("done", done, e_done);
        check("en_recover", en_recover, e_rec);
        if (m_locked) check("out", out, m_pred);
        for (int k = 0; k < NR; k++) check("snap", regs_snapshot[k*DW +: DW], m_snap[k*DW +: DW]);
    endtask

    task automatic cycle(input bit vp, input logic [AW-1:0] a, input bit dv, input logic [DW-1:0] dd);
        vp_en = vp; addr = a; d_cache_valid = dv; d_cache_data = dd;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare();
    endtask

    task automatic resolve_train(input logic [AW-1:0] a, input logic [DW-1:0] dd);
        cycle(1, a, 0, '0);
        cycle(0, '0, 1, dd);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] dd;
        model_reset();
        repeat (2) cycle(0, '0, 0, '0);
        @(negedge clk) rst_n = 1'b1;

        // Cold miss
        for (int i = 0; i < NR; i++) regs_in[i*DW +: DW] = DW'(i);
        cycle(1, 32'h100, 0, '0);
        check("cold_out", out, 0);
        check("cold_snap5", regs_snapshot[5*DW +: DW], 5);
        cycle(0, '0, 1, 32'h0);

        // Mispredict then correct re-prediction
        resolve_train(32'h104, 32'hDEAD);
        cycle(1, 32'h104, 0, '0);
        check("repredict_out", out, 32'hDEAD);
        cycle(0, '0, 1, 32'hDEAD);

        // Confidence build-up, then a wrong value
        repeat (4) resolve_train(32'h200, 32'h55);
        resolve_train(32'h200, 32'h66);

        // Lock: second request and regs change ignored; d_cache_valid in IDLE ignored
        cycle(1, 32'h200, 0, '0);
        for (int i = 0; i < NR; i++) regs_in[i*DW +: DW] = $urandom;
        cycle(1, 32'h300, 0, '0);
        check("lock_out_held", out, 32'h66);
        cycle(0, '0, 0, '0);
        cycle(0, '0, 1, 32'h66);
        cycle(0, '0, 1, 32'h1);
        cycle(1, 32'h300, 1, 32'h0);
        cycle(0, '0, 1, 32'h9);

        // Aliasing: same index, different tag
        resolve_train(32'h100, 32'h7);
        cycle(1, 32'h140, 0, '0);
        check("alias_out", out, 0);
        cycle(0, '0, 1, 32'h8);
        cycle(1, 32'h100, 0, '0);
        check("alias_replaced", out, 0);
        cycle(0, '0, 1, 32'h7);

        // Async reset while LOCKED
        cycle(1, 32'h104, 0, '0);
        rst_n = 1'b0;
        #1;
        check("rst_lock", vp_lock_out, 0);
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_snap", |regs_snapshot, 0);
        model_reset();
        cycle(0, '0, 1, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        cycle(1, 32'h104, 0, '0);
        check("post_rst_miss", out, 0);
        cycle(0, '0, 1, 32'hDEAD);

        // Random traffic over a small, aliasing address pool
        for (int n = 0; n < 800; n++) begin
            a = (AW'($urandom_range(0, 2)) << 6) | (AW'($urandom_range(0, 3)) << 2) | AW'($urandom_range(0, 3));
            if (m_locked && $urandom_range(0, 3) != 0) dd = m_pred;
            else dd = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < NR; i++) regs_in[i*DW +: DW] = $urandom;
            cycle(bit'($urandom_range(0, 1)), a, $urandom_range(0, 2) == 0, dd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
